// File: rtl/mips_mem_pkg.sv
// Shared types for the multicycle memory-access stage: FSM states, access kinds,
// the default bus width and the strobe-priority helper.
package mips_mem_pkg;

  localparam int MEM_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
  typedef enum logic [1:0] {FETCH, LOAD, STORE} mem_kind_t;

  // Store wins over fetch, fetch wins over load when strobes collide.
  function automatic mem_kind_t pick_kind(input logic irw, input logic mw);
    if (mw)       return STORE;
    else if (irw) return FETCH;
    else          return LOAD;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles without an ack; expired_o flags the cycle that reaches TIMEOUT.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Combinational so the FSM leaves BUSY right after the TIMEOUT-th silent cycle.
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_interface.sv
// Memory-access stage: turns fetch/load/store strobes into a req/ack transaction,
// holds IR and MDR, and stalls the controller until the access completes.
module mem_interface
  import mips_mem_pkg::*;
#(
  parameter int WIDTH   = MEM_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] wd,
  input  logic             irwrite,
  input  logic             memread,
  input  logic             memwrite,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] data,
  output logic             stall,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  mem_state_t       state_q;
  mem_kind_t        kind_q;
  logic [WIDTH-1:0] instr_q, data_q, mem_adr_q, mem_wdata_q;
  logic             mem_req_q, mem_we_q, err_q;
  logic             cmd, multi, misaligned, ctr_clr, ctr_en, expired;

  assign cmd        = irwrite | memread | memwrite;
  assign multi      = (irwrite & memread) | (irwrite & memwrite) | (memread & memwrite);
  assign misaligned = |adr[1:0];
  assign ctr_clr    = (state_q == IDLE) && cmd;
  assign ctr_en     = (state_q == BUSY) && !mem_ack;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (ctr_clr),
    .en_i      (ctr_en),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      kind_q      <= FETCH;
      instr_q     <= '0;
      data_q      <= '0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd) begin
            if (multi || misaligned)
              err_q <= 1'b1;
            if (misaligned) begin
              state_q <= DONE;
            end else begin
              mem_adr_q   <= adr;
              mem_wdata_q <= wd;
              mem_we_q    <= memwrite;
              kind_q      <= pick_kind(irwrite, memwrite);
              mem_req_q   <= 1'b1;
              state_q     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (kind_q == FETCH)
              instr_q <= mem_rdata;
            else if (kind_q == LOAD)
              data_q <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end else if (expired) begin
            err_q     <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by reset_n so a strobe held during reset cannot raise a stall.
  assign stall     = reset_n && (((state_q == IDLE) && cmd) || (state_q == BUSY));
  assign instr     = instr_q;
  assign data      = data_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface (TIMEOUT=4): expected IR/MDR contents are
// queued when an access is issued and popped when the stage leaves its stall.
module tb_mem_interface;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] adr, wd, mem_rdata;
  logic        irwrite, memread, memwrite, mem_ack;
  logic [31:0] instr, data, mem_adr, mem_wdata;
  logic        stall, err, mem_req, mem_we;

  int n_assert = 0;
  int n_fail   = 0;
  int s_cnt, r_cnt;
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_data_q[$];

  mem_interface #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .adr       (adr),
    .wd        (wd),
    .irwrite   (irwrite),
    .memread   (memread),
    .memwrite  (memwrite),
    .instr     (instr),
    .data      (data),
    .stall     (stall),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Runs one access whose strobes are already driven; returns on the first
  // non-stalled cycle (DONE). Acks on the ack_cycle-th BUSY cycle (0 = never).
  task automatic run_access(input int ack_cycle, input logic [31:0] rdata,
                            input logic [31:0] e_adr, input logic e_we,
                            input logic [31:0] e_wdata,
                            output int stall_cnt, output int req_cnt);
    stall_cnt = 0;
    req_cnt   = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall) break;
      stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check("mem_adr", mem_adr, e_adr);
          check("mem_we", 32'(mem_we), 32'(e_we));
          check("mem_wdata", mem_wdata, e_wdata);
        end
        if (req_cnt == ack_cycle) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] ei, ed;
    ei = exp_instr_q.pop_front();
    ed = exp_data_q.pop_front();
    check({tag, "_instr"}, instr, ei);
    check({tag, "_data"}, data, ed);
  endtask

  task automatic end_access();
    irwrite  = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0; adr = '0; wd = '0; mem_rdata = '0;
    memread = 1'b0; memwrite = 1'b0; mem_ack = 1'b0;
    irwrite = 1'b1;
    #3;
    check("rst_stall", 32'(stall), 32'd0);
    irwrite = 1'b0;
    #1;
    check("rst_instr", instr, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_adr", mem_adr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Fetch, zero-wait memory
    adr = 32'h4; wd = 32'h0; irwrite = 1'b1;
    exp_instr_q.push_back(32'h8C010008); exp_data_q.push_back(32'h0);
    run_access(1, 32'h8C010008, 32'h4, 1'b0, 32'h0, s_cnt, r_cnt);
    $display("txn fetch adr=%h stall=%0d req=%0d instr=%h", adr, s_cnt, r_cnt, instr);
    check("fetch_stall", 32'(s_cnt), 32'd2);
    check("fetch_req", 32'(r_cnt), 32'd1);
    check_regs("fetch");
    check("fetch_err", 32'(err), 32'd0);
    step();
    // Strobe still high in the IDLE after DONE: a new command is seen, then withdrawn.
    check("b2b_idle_stall", 32'(stall), 32'd1);
    end_access();

    // Load, ack on third BUSY cycle
    adr = 32'h10; wd = 32'h0; memread = 1'b1;
    exp_instr_q.push_back(32'h8C010008); exp_data_q.push_back(32'hDEADBEEF);
    run_access(3, 32'hDEADBEEF, 32'h10, 1'b0, 32'h0, s_cnt, r_cnt);
    $display("txn load adr=%h stall=%0d req=%0d data=%h", adr, s_cnt, r_cnt, data);
    check("load_stall", 32'(s_cnt), 32'd4);
    check("load_req", 32'(r_cnt), 32'd3);
    check_regs("load");
    end_access();

    // Store; read data on the bus must not reach IR/MDR
    adr = 32'h20; wd = 32'h12345678; memwrite = 1'b1;
    exp_instr_q.push_back(32'h8C010008); exp_data_q.push_back(32'hDEADBEEF);
    run_access(2, 32'hBAD0BAD0, 32'h20, 1'b1, 32'h12345678, s_cnt, r_cnt);
    $display("txn store adr=%h stall=%0d req=%0d", adr, s_cnt, r_cnt);
    check("store_stall", 32'(s_cnt), 32'd3);
    check_regs("store");
    check("store_err", 32'(err), 32'd0);
    end_access();

    // Misaligned load
    adr = 32'h22; memread = 1'b1;
    exp_instr_q.push_back(32'h8C010008); exp_data_q.push_back(32'hDEADBEEF);
    run_access(1, 32'h77777777, 32'h0, 1'b0, 32'h0, s_cnt, r_cnt);
    $display("txn misaligned adr=%h stall=%0d req=%0d err=%0d", adr, s_cnt, r_cnt, err);
    check("mis_stall", 32'(s_cnt), 32'd1);
    check("mis_req", 32'(r_cnt), 32'd0);
    check("mis_err", 32'(err), 32'd1);
    check_regs("mis");
    end_access();

    reset_n = 1'b0; #1; reset_n = 1'b1;
    step();
    check("rst2_err", 32'(err), 32'd0);

    // Conflicting strobes: store wins, err set
    adr = 32'h40; wd = 32'hCAFEF00D; irwrite = 1'b1; memwrite = 1'b1;
    exp_instr_q.push_back(32'h0); exp_data_q.push_back(32'h0);
    run_access(1, 32'h11111111, 32'h40, 1'b1, 32'hCAFEF00D, s_cnt, r_cnt);
    $display("txn conflict adr=%h stall=%0d req=%0d err=%0d", adr, s_cnt, r_cnt, err);
    check("conf_stall", 32'(s_cnt), 32'd2);
    check("conf_err", 32'(err), 32'd1);
    check_regs("conf");
    end_access();

    reset_n = 1'b0; #1; reset_n = 1'b1;
    step();

    // Load to make MDR nonzero, then a fetch that times out
    adr = 32'h8; wd = 32'h0; memread = 1'b1;
    exp_instr_q.push_back(32'h0); exp_data_q.push_back(32'h0BADCAFE);
    run_access(2, 32'h0BADCAFE, 32'h8, 1'b0, 32'h0, s_cnt, r_cnt);
    $display("txn load adr=%h stall=%0d req=%0d data=%h", adr, s_cnt, r_cnt, data);
    check_regs("load2");
    end_access();

    adr = 32'hC; irwrite = 1'b1;
    exp_instr_q.push_back(32'h0); exp_data_q.push_back(32'h0BADCAFE);
    run_access(0, 32'h0, 32'hC, 1'b0, 32'h0, s_cnt, r_cnt);
    $display("txn timeout adr=%h stall=%0d req=%0d err=%0d", adr, s_cnt, r_cnt, err);
    check("to_stall", 32'(s_cnt), 32'd5);
    check("to_req", 32'(r_cnt), 32'd4);
    check("to_err", 32'(err), 32'd1);
    check_regs("to");
    end_access();

    // Reset while BUSY; late ack must be ignored
    adr = 32'h30; memread = 1'b1;
    step();
    #1;
    check("mid_req_busy", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_req_async", 32'(mem_req), 32'd0);
    check("mid_stall", 32'(stall), 32'd0);
    check("mid_data", data, 32'd0);
    check("mid_instr", instr, 32'd0);
    memread = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55555555;
    step();
    reset_n = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    $display("txn reset_mid adr=%h req=%0d data=%h", adr, mem_req, data);
    check("late_ack_data", data, 32'd0);
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_stall", 32'(stall), 32'd0);
    check("late_ack_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
# mem_interface

Sequential memory-access stage between the multicycle control FSM/datapath and a unified instruction/data memory with variable latency. Turns the control strobes for a fetch, load or store into a req/ack transaction on the memory side. Holds the fetched word in the instruction register and the loaded word in the memory data register. Raises `stall` so the control FSM holds its state until the access completes.

## Interface
Parameters:
- `WIDTH`, 32: address and data width.
- `TIMEOUT`, 16: maximum BUSY cycles without `mem_ack` before abort (≥1).

Ports:
- `clk`  in  1  clock; rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `adr`  in  WIDTH  byte address, already muxed by the datapath (PC or ALUOut).
- `wd`  in  WIDTH  store data.
- `irwrite`  in  1  instruction fetch request.
- `memread`  in  1  data load request.
- `memwrite`  in  1  data store request.
- `instr`  out  WIDTH  instruction register.
- `data`  out  WIDTH  memory data register.
- `stall`  out  1  controller must hold its state.
- `err`  out  1  sticky error flag (misaligned access, timeout or conflicting strobes).
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write enable.
- `mem_adr`  out  WIDTH  memory address.
- `mem_wdata`  out  WIDTH  memory write data.
- `mem_rdata`  in  WIDTH  memory read data.
- `mem_ack`  in  1  memory completion, one cycle.

## Operation
- `cmd` = `irwrite` | `memread` | `memwrite`.
- Priority when more than one strobe is high: `memwrite` > `irwrite` > `memread`. Any multi-strobe cycle also sets `err`.
- **IDLE**
  - No `cmd`: stay IDLE.
  - `cmd` with `adr[1:0]` ≠ 0: set `err`, go to DONE, no memory request.
  - `cmd` with aligned `adr`: latch `adr`, `wd`, kind (FETCH/LOAD/STORE) into `mem_adr`, `mem_wdata`, `mem_we` and the kind register. Clear the timeout counter. Go to BUSY.
- **BUSY**
  - `mem_req` = 1.
  - On `mem_ack`: FETCH writes `mem_rdata` to `instr`; LOAD writes it to `data`; STORE writes nothing. Go to DONE.
  - No ack: increment the counter. On reaching `TIMEOUT`, set `err`, leave `instr`/`data` unchanged, go to DONE.
- **DONE**: `stall` = 0 for one cycle, then unconditionally IDLE. A `cmd` still high in DONE is treated as already served and ignored.
- `stall` = (IDLE & `cmd`) | BUSY. It is combinational, so the controller holds in the same cycle it raises a strobe.
- `mem_ack` outside BUSY is ignored.
- `err` is cleared only by reset.
- `mem_adr`, `mem_wdata` and `mem_we` hold their latched values until the next accepted command.

## Timing
- Reset values:
  - state = IDLE; `instr` = 0, `data` = 0, `mem_req` = 0, `mem_we` = 0, `mem_adr` = 0, `mem_wdata` = 0, `err` = 0, counter = 0.
  - `stall` = 0 while reset is asserted.
- Reset asserted mid-transaction: `mem_req` drops immediately (asynchronously). The in-flight ack is lost and the `instr`/`data` registers are reset.
- Minimum access: cycle 0 = IDLE with `cmd`, `stall` = 1. Cycle 1 = BUSY, `mem_req` = 1, `mem_ack` = 1. Cycle 2 = DONE, `stall` = 0, `instr`/`data` valid.
- With an ack in BUSY cycle k (k ≥ 1), `stall` is high for k+1 cycles.
- Timeout: DONE is entered the cycle after the `TIMEOUT`-th BUSY cycle without ack. `mem_req` is high for exactly `TIMEOUT` cycles.
- Misaligned access: IDLE → DONE directly, `stall` high for exactly one cycle.
- Back-to-back commands: a new command is accepted in the IDLE cycle following DONE, never in DONE itself.

## Structure
- Shared package `mips_mem_pkg`:
  - `mem_state_t` enum (IDLE, BUSY, DONE);
  - `mem_kind_t` enum (FETCH, LOAD, STORE);
  - the default `WIDTH`.
- One sub-module, `mem_timeout_ctr`: clear/enable/expired counter parameterised by `TIMEOUT`, same clock and reset.

## Test plan
- Fetch with 0-wait memory:
  - Stimulus: `adr`=0x00000004, `irwrite`=1, memory returns 0x8C010008 with ack in the first BUSY cycle.
  - Response: `mem_req` high 1 cycle; `instr`=0x8C010008 at cycle 2; `stall` high cycles 0–1; `err`=0.
- Load with 3-cycle memory latency:
  - Stimulus: `adr`=0x00000010, `memread`=1, ack on BUSY cycle 3 with 0xDEADBEEF.
  - Response: `data`=0xDEADBEEF; `instr` unchanged; `stall` high 4 cycles.
- Store:
  - Stimulus: `adr`=0x00000020, `wd`=0x12345678, `memwrite`=1.
  - Response: `mem_we`=1, `mem_adr`=0x20, `mem_wdata`=0x12345678 while `mem_req`=1; `instr` and `data` unchanged.
- Misaligned and conflicting strobes:
  - Stimulus 1: `memread` with `adr`=0x00000022. Response: `err`=1, no `mem_req`, `stall` high 1 cycle.
  - Stimulus 2 (after reset): `irwrite`=1 and `memwrite`=1 together. Response: store performed, `err`=1.
- Timeout with `TIMEOUT`=4, memory never acks: `mem_req` high exactly 4 cycles, then `err`=1, DONE, `instr`/`data` unchanged.
- Reset during BUSY: `reset_n` low → `mem_req`=0 immediately; `instr`=`data`=0. A late `mem_ack` after reset is ignored.
